timer_digit_counter: RTL and testbench

- Downstream consumer of the one-hot digit-select shift register.
- Holds the four BCD timer digits MM:SS, organised as:
  - digit 3: minutes tens
  - digit 2: minutes ones
  - digit 1: seconds tens
  - digit 0: seconds ones
- In EDIT, increments or decrements the digit flagged by the one-hot select.
- In RUN, counts down once per 1 Hz tick and flags completion at 00:00.
- Outputs feed the seven-segment display driver and the alarm logic.

---
 rtl/timer_digit_counter.sv | 129 ++++++++++++
 tb/tb_timer_digit_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_digit_counter.sv
// MM:SS BCD timer digits: per-digit editing in EDIT, 1 Hz countdown in RUN,
// completion flag in DONE. All outputs come straight from flops.
//
// state | meaning
// ------+-----------------------------------------------------------
// EDIT  | digits editable via one-hot select + inc/dec; start arms RUN
// RUN   | digits count down on each 1 Hz tick; stop pauses to EDIT
// DONE  | countdown reached 00:00; any user pulse returns to EDIT
module timer_digit_counter #(
  parameter int unsigned MIN_TENS_MAX = 9,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_digit_select,
  input  logic        i_inc,
  input  logic        i_dec,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_tick_1hz,
  output logic [15:0] o_digits,
  output logic        o_running,
  output logic        o_done
);

  typedef enum logic [1:0] {
    ST_EDIT = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] MAX_D0 = 4'd9;
  localparam logic [3:0] MAX_D1 = SEC_TENS_MAX[3:0];
  localparam logic [3:0] MAX_D2 = 4'd9;
  localparam logic [3:0] MAX_D3 = MIN_TENS_MAX[3:0];
  localparam logic [3:0][3:0] DIGIT_MAX = {MAX_D3, MAX_D2, MAX_D1, MAX_D0};

  state_t          state_q, state_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic [3:0][3:0] count_dn;
  logic            count_zero;
  logic            edit_ok;
  logic            running_q, done_q;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] mx);
    return (v >= mx) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_dec(input logic [3:0] v, input logic [3:0] mx);
    return (v == 4'd0 || v > mx) ? mx : v - 4'd1;
  endfunction

  // One-second decrement of MM:SS with borrow rippling up through the digits.
  always_comb begin
    count_dn = digits_q;
    if (digits_q[0] != 4'd0) begin
      count_dn[0] = digits_q[0] - 4'd1;
    end else if (digits_q[1] != 4'd0) begin
      count_dn[0] = MAX_D0;
      count_dn[1] = digits_q[1] - 4'd1;
    end else if (digits_q[2] != 4'd0) begin
      count_dn[0] = MAX_D0;
      count_dn[1] = MAX_D1;
      count_dn[2] = digits_q[2] - 4'd1;
    end else if (digits_q[3] != 4'd0) begin
      count_dn[0] = MAX_D0;
      count_dn[1] = MAX_D1;
      count_dn[2] = MAX_D2;
      count_dn[3] = digits_q[3] - 4'd1;
    end
  end

  assign count_zero = (count_dn == '0);
  assign edit_ok    = $onehot(i_digit_select) && (i_inc ^ i_dec);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    case (state_q)
      ST_EDIT: begin
        if (i_start) begin
          if (digits_q != '0) state_d = ST_RUN;
        end else if (edit_ok) begin
          for (int i = 0; i < 4; i++) begin
            if (i_digit_select[i]) begin
              digits_d[i] = i_inc ? wrap_inc(digits_q[i], DIGIT_MAX[i])
                                  : wrap_dec(digits_q[i], DIGIT_MAX[i]);
            end
          end
        end
      end
      ST_RUN: begin
        // A tick coinciding with stop is dropped so the paused value is stable.
        if (i_stop) begin
          state_d = ST_EDIT;
        end else if (i_tick_1hz) begin
          digits_d = count_dn;
          if (count_zero) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        digits_d = '0;
        if (i_start || i_stop || i_inc || i_dec) state_d = ST_EDIT;
      end
      default: begin
        state_d = ST_EDIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_EDIT;
      digits_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign o_digits  = digits_q;
  assign o_running = running_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_timer_digit_counter.sv
// Bench for timer_digit_counter: directed scenarios plus a random walk checked
// against a seconds-based reference model.
module tb_timer_digit_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        inc = 1'b0, dec = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [15:0] digits;
  logic        running, done;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: mode 0 = EDIT, 1 = RUN, 2 = DONE
  int md[4];
  int mmode;
  int mx[4];

  timer_digit_counter #(.MIN_TENS_MAX(9), .SEC_TENS_MAX(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digit_select(sel), .i_inc(inc),
    .i_dec(dec), .i_start(start), .i_stop(stop), .i_tick_1hz(tick),
    .o_digits(digits), .o_running(running), .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_digits();
    return {md[3][3:0], md[2][3:0], md[1][3:0], md[0][3:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mmode = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic pi, input logic pd,
                            input logic pst, input logic psp, input logic pt);
    int secs;
    case (mmode)
      0: begin
        if (pst) begin
          if (md[0] + md[1] + md[2] + md[3] != 0) mmode = 1;
        end else if ((pi ^ pd) && $countones(s) == 1) begin
          for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
              if (pi) md[i] = (md[i] == mx[i]) ? 0 : md[i] + 1;
              else    md[i] = (md[i] == 0) ? mx[i] : md[i] - 1;
            end
          end
        end
      end
      1: begin
        if (psp) mmode = 0;
        else if (pt) begin
          secs = (md[3] * 10 + md[2]) * 60 + md[1] * 10 + md[0] - 1;
          md[3] = secs / 600;
          md[2] = (secs / 60) % 10;
          md[1] = (secs % 60) / 10;
          md[0] = secs % 10;
          if (secs == 0) mmode = 2;
        end
      end
      default: begin
        if (pst || psp || pi || pd) mmode = 0;
      end
    endcase
  endtask

  task automatic drive(input logic [3:0] s, input logic pi, input logic pd,
                       input logic pst, input logic psp, input logic pt);
    @(negedge clk);
    sel = s; inc = pi; dec = pd; start = pst; stop = psp; tick = pt;
    model_step(s, pi, pd, pst, psp, pt);
    @(posedge clk);
    #1;
    inc = 0; dec = 0; start = 0; stop = 0; tick = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    sel = 0; inc = 0; dec = 0; start = 0; stop = 0; tick = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic press(input logic [3:0] s, input int n);
    for (int k = 0; k < n; k++) drive(s, 1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (digits !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: digits=%h running=%b done=%b, want 0000/0/0", digits, running, done);
    end
  endtask

  task automatic test_edit_wrap();
    logic [3:0] exp_d1[6];
    exp_d1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0010, 1, 0, 0, 0, 0);
      n_cmp++;
      if (digits !== {8'h00, exp_d1[k], 4'h0}) begin
        n_err++;
        $display("FAIL edit_inc_d1 step %0d: got %h want %h", k, digits, {8'h00, exp_d1[k], 4'h0});
      end
    end
    drive(4'b0010, 0, 1, 0, 0, 0);
    n_cmp++;
    if (digits !== 16'h0050) begin
      n_err++;
      $display("FAIL edit_dec_wrap_d1: got %h want 0050", digits);
    end
  endtask

  task automatic test_run_borrow();
    do_reset();
    press(4'b0100, 1);
    drive(4'b0000, 0, 0, 1, 0, 0);
    n_cmp++;
    if (running !== 1'b1 || digits !== 16'h0100) begin
      n_err++;
      $display("FAIL start_0100: digits=%h running=%b want 0100/1", digits, running);
    end
    drive(4'b0000, 0, 0, 0, 0, 1);
    n_cmp++;
    if (digits !== 16'h0059 || running !== 1'b1) begin
      n_err++;
      $display("FAIL borrow_tick: digits=%h running=%b want 0059/1", digits, running);
    end
  endtask

  task automatic test_done();
    do_reset();
    press(4'b0001, 2);
    drive(4'b0000, 0, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 1);
    n_cmp++;
    if (digits !== 16'h0001 || running !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL tick_to_0001: digits=%h running=%b done=%b", digits, running, done);
    end
    drive(4'b0000, 0, 0, 0, 0, 1);
    n_cmp++;
    if (digits !== 16'h0000 || running !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL reach_done: digits=%h running=%b done=%b want 0000/0/1", digits, running, done);
    end
    drive(4'b0001, 1, 0, 0, 0, 0);
    n_cmp++;
    if (digits !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL done_exit_inc: digits=%h running=%b done=%b want 0000/0/0", digits, running, done);
    end
  endtask

  task automatic test_stop_priority();
    do_reset();
    press(4'b1000, 1);
    drive(4'b0000, 0, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 1, 1);
    n_cmp++;
    if (digits !== 16'h1000 || running !== 1'b0) begin
      n_err++;
      $display("FAIL stop_over_tick: digits=%h running=%b want 1000/0", digits, running);
    end
  endtask

  task automatic test_zero_start_multihot();
    do_reset();
    drive(4'b0000, 0, 0, 1, 0, 0);
    n_cmp++;
    if (running !== 1'b0 || digits !== 16'h0000) begin
      n_err++;
      $display("FAIL start_at_zero: digits=%h running=%b want 0000/0", digits, running);
    end
    drive(4'b0011, 1, 0, 0, 0, 0);
    n_cmp++;
    if (digits !== 16'h0000) begin
      n_err++;
      $display("FAIL multihot_inc: got %h want 0000", digits);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(4'b0100, 5);
    press(4'b0010, 3);
    drive(4'b0000, 0, 0, 1, 0, 0);
    n_cmp++;
    if (digits !== 16'h0530 || running !== 1'b1) begin
      n_err++;
      $display("FAIL setup_0530: digits=%h running=%b", digits, running);
    end
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: digits=%h running=%b want 0000/0", digits, running);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic pi, pd, pst, psp, pt;
    int r;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 11);
      s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      pi = (r == 0 || r == 1 || r == 2 || r == 6);
      pd = (r == 3 || r == 4 || r == 6);
      pst = (r == 5);
      psp = (r == 7);
      pt = ($urandom_range(0, 2) == 0);
      drive(s, pi, pd, pst, psp, pt);
      n_cmp++;
      if (digits !== m_digits() || running !== (mmode == 1) || done !== (mmode == 2)) begin
        n_err++;
        $display("FAIL random cyc %0d: digits=%h run=%b done=%b want %h/%b/%b",
                 k, digits, running, done, m_digits(), mmode == 1, mmode == 2);
      end
    end
  endtask

  initial begin
    mx[0] = 9; mx[1] = 5; mx[2] = 9; mx[3] = 9;
    model_reset();
    test_reset();
    test_edit_wrap();
    test_run_borrow();
    test_done();
    test_stop_priority();
    test_zero_start_multihot();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
